// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: func codes, forward-select encoding and the
// per-register scoreboard entry used by rf_hazard_scoreboard / sb_entry.
package pipe_pkg;

    localparam logic [4:0] FUNC_NOP     = 5'd0;
    localparam logic [4:0] FUNC_ALU_MIN = 5'd1;
    localparam logic [4:0] FUNC_ALU_MAX = 5'd14;
    localparam logic [4:0] FUNC_LOAD    = 5'd15;

    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_AGE1 = 2'd1;
    localparam logic [1:0] FWD_AGE2 = 2'd2;
    localparam logic [1:0] FWD_AGE3 = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [1:0] age;
        logic       is_load;
    } sb_entry_t;

    // ALU instructions both read their sources and write rd.
    function automatic logic is_alu(input logic [4:0] func);
        return (func != FUNC_NOP) && (func >= FUNC_ALU_MIN) && (func <= FUNC_ALU_MAX);
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One register's in-flight write record: valid, distance (age) to the
// producing instruction and whether that producer is a load.
module sb_entry
    import pipe_pkg::*;
#(
    parameter int MAX_AGE = 3
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush_i,
    input  logic      set_i,
    input  logic      set_load_i,
    output sb_entry_t entry_o
);

    localparam logic [1:0] AGE_LAST = 2'(MAX_AGE);

    sb_entry_t entry_q;
    sb_entry_t entry_d;

    // Flush beats a new producer, which beats the ordinary age/retire step.
    always_comb begin
        entry_d = entry_q;
        if (flush_i) begin
            entry_d = '0;
        end else if (set_i) begin
            entry_d.valid   = 1'b1;
            entry_d.age     = 2'd1;
            entry_d.is_load = set_load_i;
        end else if (entry_q.valid) begin
            if (entry_q.age == AGE_LAST) begin
                entry_d = '0;
            end else begin
                entry_d.age = entry_q.age + 2'd1;
            end
        end
    end

    // Entry state register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/rf_hazard_scoreboard.sv
// Issue-side hazard scoreboard: per-register pending/age table, operand
// forward selects and load-use stall for the decode slot.
// Optional build macro SCOREBOARD_PERF_EN adds a saturating stall_count output.
module rf_hazard_scoreboard #(
    parameter int         NREG      = 8,
    parameter int         MAX_AGE   = 3,
    parameter logic [4:0] LOAD_FUNC = pipe_pkg::FUNC_LOAD,
    parameter int         LOAD_LAT  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_func,
    input  logic [$clog2(NREG)-1:0] issue_rd,
    input  logic [$clog2(NREG)-1:0] issue_rs1,
    input  logic [$clog2(NREG)-1:0] issue_rs2,
    output logic                    issue_accept,
    output logic                    stall,
    output logic [1:0]              fwd_sel1,
    output logic [1:0]              fwd_sel2
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [15:0]             stall_count
`endif
);

    import pipe_pkg::*;

    localparam int AW = $clog2(NREG);

    sb_entry_t       table_w [NREG];
    logic [NREG-1:0] set_w;
    logic            reads_w;
    logic            writes_w;
    logic            haz1_w;
    logic            haz2_w;
    sb_entry_t       src1_w;
    sb_entry_t       src2_w;

    // Func codes that read rs1/rs2 and write rd.
    function automatic logic is_rw(input logic [4:0] func);
        return is_alu(func) || (func == LOAD_FUNC);
    endfunction

    // Age of a live producer is exactly how many stages ahead its result sits.
    function automatic logic [1:0] age_to_sel(input sb_entry_t e);
        logic [1:0] sel;
        sel = FWD_RF;
        if (e.valid) begin
            case (e.age)
                2'd1:    sel = FWD_AGE1;
                2'd2:    sel = FWD_AGE2;
                2'd3:    sel = FWD_AGE3;
                default: sel = FWD_RF;
            endcase
        end
        return sel;
    endfunction

    // A load result is not yet available until it is LOAD_LAT stages ahead.
    function automatic logic load_hazard(input sb_entry_t e);
        return e.valid && e.is_load && (int'(e.age) < LOAD_LAT);
    endfunction

    // Lookup against the current table; stall and accept follow from it.
    always_comb begin
        reads_w      = is_rw(issue_func);
        writes_w     = reads_w;
        src1_w       = table_w[issue_rs1];
        src2_w       = table_w[issue_rs2];
        fwd_sel1     = reads_w ? age_to_sel(src1_w) : FWD_RF;
        fwd_sel2     = reads_w ? age_to_sel(src2_w) : FWD_RF;
        haz1_w       = reads_w && load_hazard(src1_w);
        haz2_w       = reads_w && load_hazard(src2_w);
        stall        = issue_valid && (haz1_w || haz2_w);
        issue_accept = issue_valid && !stall && !flush && !reset;
    end

    genvar g;
    generate
        for (g = 0; g < NREG; g++) begin : g_entry
            assign set_w[g] = issue_accept && writes_w && (issue_rd == AW'(g));

            sb_entry #(
                .MAX_AGE    (MAX_AGE)
            ) u_entry (
                .clk        (clk),
                .reset      (reset),
                .flush_i    (flush),
                .set_i      (set_w[g]),
                .set_load_i (issue_func == LOAD_FUNC),
                .entry_o    (table_w[g])
            );
        end
    endgenerate

`ifdef SCOREBOARD_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    // Count stalled cycles, holding at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Counter register; only reset clears it, flush does not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rf_hazard_scoreboard.sv
// Self-checking bench for rf_hazard_scoreboard. Expected outputs for each
// driven decode slot are queued at drive time and checked mid-cycle.
module tb_rf_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       issue_valid;
    logic [4:0] issue_func;
    logic [2:0] issue_rd;
    logic [2:0] issue_rs1;
    logic [2:0] issue_rs2;
    logic       issue_accept;
    logic       stall;
    logic [1:0] fwd_sel1;
    logic [1:0] fwd_sel2;
`ifdef SCOREBOARD_PERF_EN
    logic [15:0] stall_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int step_no  = 0;

    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    rf_hazard_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_func   (issue_func),
        .issue_rd     (issue_rd),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_accept (issue_accept),
        .stall        (stall),
        .fwd_sel1     (fwd_sel1),
        .fwd_sel2     (fwd_sel2)
`ifdef SCOREBOARD_PERF_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pack {stall, accept, sel1, sel2}.
    function automatic logic [5:0] E(input logic st, input logic ac,
                                     input logic [1:0] s1, input logic [1:0] s2);
        return {st, ac, s1, s2};
    endfunction

    task automatic drive(input logic v, input logic [4:0] f, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2, input logic fl);
        issue_valid = v;
        issue_func  = f;
        issue_rd    = rd;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        flush       = fl;
    endtask

    task automatic compare_out();
        logic [5:0] e;
        e = exp_q.pop_front();
        check_eq($sformatf("s%0d_stall", step_no), 32'(stall),        32'(e[5]));
        check_eq($sformatf("s%0d_acc",   step_no), 32'(issue_accept), 32'(e[4]));
        check_eq($sformatf("s%0d_sel1",  step_no), 32'(fwd_sel1),     32'(e[3:2]));
        check_eq($sformatf("s%0d_sel2",  step_no), 32'(fwd_sel2),     32'(e[1:0]));
    endtask

    // One decode slot: drive after the edge, check outputs at the falling edge.
    task automatic step(input logic v, input logic [4:0] f, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2, input logic fl,
                        input logic [5:0] exp);
        @(posedge clk);
        #1;
        step_no++;
        drive(v, f, rd, rs1, rs2, fl);
        exp_q.push_back(exp);
        @(negedge clk);
        compare_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1'b1, 5'd1, 3'd3, 3'd0, 3'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_stall", 32'(stall),        32'd0);
        check_eq("rst_acc",   32'(issue_accept), 32'd0);
        check_eq("rst_sel1",  32'(fwd_sel1),     32'd0);
        check_eq("rst_sel2",  32'(fwd_sel2),     32'd0);
        reset = 1'b0;

        // ALU writer r2, then readers at distance 1..4.
        step(1, 5'd3,  3'd2, 3'd0, 3'd0, 0, E(0,1,0,0));
        step(1, 5'd1,  3'd6, 3'd2, 3'd0, 0, E(0,1,1,0));
        step(1, 5'd1,  3'd6, 3'd2, 3'd0, 0, E(0,1,2,0));
        step(1, 5'd1,  3'd6, 3'd2, 3'd0, 0, E(0,1,3,0));
        step(1, 5'd1,  3'd6, 3'd2, 3'd0, 0, E(0,1,0,0));

        // Load r4 followed immediately by a user on rs2.
        step(1, 5'd15, 3'd4, 3'd0, 3'd0, 0, E(0,1,0,0));
        step(1, 5'd1,  3'd6, 3'd0, 3'd4, 0, E(1,0,0,1));
        step(1, 5'd1,  3'd6, 3'd0, 3'd4, 0, E(0,1,0,2));

        // Two writers to r5: the younger one wins.
        step(1, 5'd3,  3'd5, 3'd0, 3'd0, 0, E(0,1,0,0));
        step(1, 5'd3,  3'd5, 3'd0, 3'd0, 0, E(0,1,0,0));
        step(1, 5'd1,  3'd6, 3'd5, 3'd0, 0, E(0,1,1,0));
        step(1, 5'd1,  3'd6, 3'd5, 3'd0, 0, E(0,1,2,0));

        // Writer r1, then flush (lookup still sees r1, nothing accepted).
        step(1, 5'd3,  3'd1, 3'd0, 3'd0, 0, E(0,1,0,0));
        step(1, 5'd3,  3'd3, 3'd1, 3'd0, 1, E(0,0,1,0));
        step(1, 5'd1,  3'd6, 3'd1, 3'd3, 0, E(0,1,0,0));

        // rd equal to rs1: lookup uses the old (empty) entry.
        step(1, 5'd3,  3'd2, 3'd2, 3'd0, 0, E(0,1,0,0));
        step(1, 5'd1,  3'd6, 3'd2, 3'd2, 0, E(0,1,1,1));
        // Non-reading func code: no selects, no write.
        step(1, 5'd20, 3'd7, 3'd2, 3'd2, 0, E(0,1,0,0));
        step(1, 5'd1,  3'd6, 3'd7, 3'd0, 0, E(0,1,0,0));

        // Load r3; an empty decode slot does not stall.
        step(1, 5'd15, 3'd3, 3'd0, 3'd0, 0, E(0,1,0,0));
        step(0, 5'd1,  3'd6, 3'd3, 3'd0, 0, E(0,0,1,0));
        step(1, 5'd0,  3'd6, 3'd3, 3'd3, 0, E(0,1,0,0));

        // Asynchronous reset in the middle of a load-use stall.
        step(1, 5'd15, 3'd4, 3'd0, 3'd0, 0, E(0,1,0,0));
        @(posedge clk);
        #1;
        step_no++;
        drive(1, 5'd1, 3'd6, 3'd0, 3'd4, 0);
        exp_q.push_back(E(1,0,0,1));
        #2;
        compare_out();
        reset = 1'b1;
        #1;
        check_eq("arst_stall", 32'(stall),        32'd0);
        check_eq("arst_acc",   32'(issue_accept), 32'd0);
        check_eq("arst_sel2",  32'(fwd_sel2),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 5'd1,  3'd6, 3'd4, 3'd4, 0, E(0,1,0,0));
`ifdef SCOREBOARD_PERF_EN
        check_eq("cnt_after_rst", 32'(stall_count), 32'd0);
`endif

        // Three load-use stalls.
        for (int i = 0; i < 3; i++) begin
            step(1, 5'd15, 3'd4, 3'd0, 3'd0, 0, E(0,1,0,0));
            step(1, 5'd2,  3'd6, 3'd0, 3'd4, 0, E(1,0,0,1));
            step(1, 5'd2,  3'd6, 3'd0, 3'd4, 0, E(0,1,0,2));
        end
`ifdef SCOREBOARD_PERF_EN
        check_eq("cnt_3", 32'(stall_count), 32'd3);
`endif
        step(0, 5'd0,  3'd0, 3'd0, 3'd0, 1, E(0,0,0,0));
        step(1, 5'd1,  3'd6, 3'd4, 3'd6, 0, E(0,1,0,0));
`ifdef SCOREBOARD_PERF_EN
        check_eq("cnt_flush", 32'(stall_count), 32'd3);
        reset = 1'b1;
        #1;
        check_eq("cnt_reset", 32'(stall_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
